qos_mm_master: RTL and testbench

QOS_MM_MASTER -- requirements
Module: qos_mm_master

---
 rtl/qos_mm_pkg.sv | 33 +++
 rtl/qos_poll_timer.sv | 29 ++
 rtl/qos_mm_master.sv | 152 +++++++++++++++
 tb/tb_qos_mm_master.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/qos_mm_pkg.sv
// Shared definitions for qos_mm_master: register map, FSM states, config/status field offsets.
// Optional feature macro: QOS_MM_CFG_READBACK_EN (adds the config readback states).
package qos_mm_pkg;

  localparam logic [7:0] ADDR_CFG    = 8'h00;
  localparam logic [7:0] ADDR_STATUS = 8'h01;
  localparam logic [7:0] ADDR_ERR    = 8'h02;

  // Config word layout: {reset_timer, channel_priority, manual_channel, manual_enable, fallback_enable}
  localparam int unsigned CFG_FALLBACK_EN_BIT = 0;
  localparam int unsigned CFG_MANUAL_EN_BIT   = 1;
  localparam int unsigned CFG_MANUAL_CH_LSB   = 2;
  localparam int unsigned CFG_PRIORITY_LSB    = 4;
  localparam int unsigned CFG_RESET_TIMER_LSB = 12;

  localparam int unsigned STAT_ACTIVE_LSB   = 0;
  localparam int unsigned STAT_PRESENCE_LSB = 2;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD_STAT,
    WT_STAT,
    RD_ERR,
    WT_ERR
`ifdef QOS_MM_CFG_READBACK_EN
    ,
    RD_CFG,
    WT_CFG
`endif
  } state_t;

endpackage

// File: rtl/qos_poll_timer.sv
// Free-running poll down-counter; raises pending as the count reaches zero, cleared by the master.
module qos_poll_timer #(
  parameter int unsigned POLL_PERIOD = 20
) (
  input  logic clk,
  input  logic rstn,
  input  logic clear,
  output logic pending
);

  localparam int unsigned CW = $clog2(POLL_PERIOD);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count   <= CW'(POLL_PERIOD - 1);
      pending <= 1'b0;
    end else begin
      count <= (count == '0) ? CW'(POLL_PERIOD - 1) : count - CW'(1);
      // An expiry landing on an already-set or just-consumed flag is dropped.
      if (clear)
        pending <= 1'b0;
      else if (count == CW'(1))
        pending <= 1'b1;
    end
  end

endmodule

// File: rtl/qos_mm_master.sv
// Memory-mapped QoS master: host config writes and periodic status/error polling.
// Optional feature macro: QOS_MM_CFG_READBACK_EN (read back and compare each config write).
module qos_mm_master
  import qos_mm_pkg::*;
#(
  parameter int unsigned POLL_PERIOD = 20,
  parameter int unsigned RD_LAT      = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        cfg_valid,
  input  logic [31:0] cfg_data,
  output logic        cfg_ready,
  output logic        mm_write_en,
  output logic        mm_read_en,
  output logic [7:0]  mm_addr,
  output logic [31:0] mm_wdata,
  input  logic [31:0] mm_rdata,
  output logic [1:0]  active_ch,
  output logic [3:0]  presence,
  output logic [31:0] err_snap,
  output logic        snap_valid,
  output logic        cfg_mismatch
);

  localparam int unsigned LW = $clog2(RD_LAT + 1);

  state_t        state, state_n;
  logic [LW-1:0] wait_cnt;
  logic          poll_pending, poll_clear;
  logic          cap_stat, cap_err;
`ifdef QOS_MM_CFG_READBACK_EN
  logic          cap_cfg;
`endif

  qos_poll_timer #(.POLL_PERIOD(POLL_PERIOD)) u_timer (
    .clk     (clk),
    .rstn    (rstn),
    .clear   (poll_clear),
    .pending (poll_pending)
  );

  // Strobes decode straight from state so reset removes them without waiting for an edge.
  assign cfg_ready   = rstn && (state == IDLE);
  assign mm_write_en = (state == WR);
`ifdef QOS_MM_CFG_READBACK_EN
  assign mm_read_en  = (state == RD_STAT) || (state == RD_ERR) || (state == RD_CFG);
`else
  assign mm_read_en  = (state == RD_STAT) || (state == RD_ERR);
`endif

  always_comb begin
    state_n    = state;
    poll_clear = 1'b0;
    cap_stat   = 1'b0;
    cap_err    = 1'b0;
`ifdef QOS_MM_CFG_READBACK_EN
    cap_cfg    = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (cfg_valid) begin
          state_n = WR;
        end else if (poll_pending) begin
          state_n    = RD_STAT;
          poll_clear = 1'b1;
        end
      end
`ifdef QOS_MM_CFG_READBACK_EN
      WR:      state_n = RD_CFG;
`else
      WR:      state_n = IDLE;
`endif
      RD_STAT: state_n = WT_STAT;
      WT_STAT: begin
        if (wait_cnt == '0) begin
          cap_stat = 1'b1;
          state_n  = RD_ERR;
        end
      end
      RD_ERR:  state_n = WT_ERR;
      WT_ERR: begin
        if (wait_cnt == '0) begin
          cap_err = 1'b1;
          state_n = IDLE;
        end
      end
`ifdef QOS_MM_CFG_READBACK_EN
      RD_CFG:  state_n = WT_CFG;
      WT_CFG: begin
        if (wait_cnt == '0) begin
          cap_cfg = 1'b1;
          state_n = IDLE;
        end
      end
`endif
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      mm_addr    <= '0;
      mm_wdata   <= '0;
      active_ch  <= '0;
      presence   <= '0;
      err_snap   <= '0;
      snap_valid <= 1'b0;
    end else begin
      state      <= state_n;
      snap_valid <= cap_err;
      // Wait counter is armed by every read strobe and idles at zero elsewhere.
      if (mm_read_en)
        wait_cnt <= LW'(RD_LAT - 1);
      else if (wait_cnt != '0)
        wait_cnt <= wait_cnt - LW'(1);
      case (state_n)
        WR: begin
          mm_addr  <= ADDR_CFG;
          mm_wdata <= cfg_data;
        end
        RD_STAT: mm_addr <= ADDR_STATUS;
        RD_ERR:  mm_addr <= ADDR_ERR;
`ifdef QOS_MM_CFG_READBACK_EN
        RD_CFG:  mm_addr <= ADDR_CFG;
`endif
        default: ;
      endcase
      if (cap_stat) begin
        active_ch <= mm_rdata[STAT_ACTIVE_LSB +: 2];
        presence  <= mm_rdata[STAT_PRESENCE_LSB +: 4];
      end
      if (cap_err)
        err_snap <= mm_rdata;
    end
  end

`ifdef QOS_MM_CFG_READBACK_EN
  // mm_wdata still holds the word just written, so it is the reference for the readback.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      cfg_mismatch <= 1'b0;
    else if (cap_cfg && (mm_rdata != mm_wdata))
      cfg_mismatch <= 1'b1;
  end
`else
  assign cfg_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_qos_mm_master.sv
// Bench for qos_mm_master: random host config traffic against a transaction-schedule reference model.
// Honours QOS_MM_CFG_READBACK_EN when the design is built with it.
module tb_qos_mm_master;

  localparam int P = 20;
  localparam int L = 2;

  logic        clk       = 1'b0;
  logic        rstn      = 1'b0;
  logic        cfg_valid = 1'b0;
  logic [31:0] cfg_data  = '0;
  logic [31:0] mm_rdata  = '0;
  logic        cfg_ready, mm_write_en, mm_read_en, snap_valid, cfg_mismatch;
  logic [7:0]  mm_addr;
  logic [31:0] mm_wdata, err_snap;
  logic [1:0]  active_ch;
  logic [3:0]  presence;

  qos_mm_master #(.POLL_PERIOD(P), .RD_LAT(L)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .cfg_valid    (cfg_valid),
    .cfg_data     (cfg_data),
    .cfg_ready    (cfg_ready),
    .mm_write_en  (mm_write_en),
    .mm_read_en   (mm_read_en),
    .mm_addr      (mm_addr),
    .mm_wdata     (mm_wdata),
    .mm_rdata     (mm_rdata),
    .active_ch    (active_ch),
    .presence     (presence),
    .err_snap     (err_snap),
    .snap_valid   (snap_valid),
    .cfg_mismatch (cfg_mismatch)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned passes = 0;

  // Reference model: cycle c counts rising edges since reset release; a transaction
  // started at edge c occupies a fixed number of cycles derived from P and L.
  int          c, idle_from, wr_t, poll_t;
  bit          pend, accepted;
  logic [31:0] wr_word, stat_val, err_val, nxt_stat, nxt_err;
  logic        e_we, e_re, e_snap, e_ready, e_mis;
  logic [7:0]  e_addr;
  logic [31:0] e_wdata, e_err;
  logic [1:0]  e_ach;
  logic [3:0]  e_pres;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s cycle %0d: got 0x%0h, expected 0x%0h", tag, c, got, exp);
  endtask

  function automatic logic [31:0] readback_word(input logic [31:0] w);
    return (w == 32'h3) ? 32'h0 : w;
  endfunction

  task automatic model_reset();
    c = 0; idle_from = 0; wr_t = -100; poll_t = -100;
    pend = 0; accepted = 0; wr_word = '0;
    e_we = 0; e_re = 0; e_snap = 0; e_ready = 1; e_mis = 0;
    e_addr = '0; e_wdata = '0; e_err = '0; e_ach = '0; e_pres = '0;
  endtask

  task automatic model_edge();
    bit was_idle, started;
    c++;
    was_idle = (c - 1 >= idle_from);
    started  = 0;
    accepted = 0;
    if (was_idle && cfg_valid) begin
      accepted = 1;
      wr_t     = c;
      wr_word  = cfg_data;
`ifdef QOS_MM_CFG_READBACK_EN
      idle_from = c + 2 + L;
`else
      idle_from = c + 1;
`endif
    end else if (was_idle && pend) begin
      started   = 1;
      poll_t    = c;
      stat_val  = nxt_stat;
      err_val   = nxt_err;
      nxt_stat  = $urandom;
      nxt_err   = $urandom;
      idle_from = c + 2 + 2 * L;
    end
    if (started) pend = 0;
    else if (c % P == P - 1) pend = 1;

    e_we = (c == wr_t);
    e_re = (c == poll_t) || (c == poll_t + 1 + L);
    if (c == wr_t) begin e_addr = 8'h00; e_wdata = wr_word; end
    if (c == poll_t) e_addr = 8'h01;
    if (c == poll_t + 1 + L) begin
      e_addr = 8'h02;
      e_ach  = stat_val[1:0];
      e_pres = stat_val[5:2];
    end
`ifdef QOS_MM_CFG_READBACK_EN
    if (c == wr_t + 1) begin e_re = 1; e_addr = 8'h00; end
    if (c == wr_t + 2 + L && readback_word(wr_word) != wr_word) e_mis = 1;
`endif
    e_snap = (c == poll_t + 2 + 2 * L);
    if (e_snap) e_err = err_val;
    e_ready = (c >= idle_from);
  endtask

  task automatic check_outputs();
    check("cfg_ready", cfg_ready, e_ready);
    check("mm_write_en", mm_write_en, e_we);
    check("mm_read_en", mm_read_en, e_re);
    check("mm_addr", mm_addr, e_addr);
    check("mm_wdata", mm_wdata, e_wdata);
    check("active_ch", active_ch, e_ach);
    check("presence", presence, e_pres);
    check("err_snap", err_snap, e_err);
    check("snap_valid", snap_valid, e_snap);
    check("cfg_mismatch", cfg_mismatch, e_mis);
  endtask

  task automatic check_zero();
    check("rst_cfg_ready", cfg_ready, 0);
    check("rst_write_en", mm_write_en, 0);
    check("rst_read_en", mm_read_en, 0);
    check("rst_addr", mm_addr, 0);
    check("rst_wdata", mm_wdata, 0);
    check("rst_active_ch", active_ch, 0);
    check("rst_presence", presence, 0);
    check("rst_err_snap", err_snap, 0);
    check("rst_snap_valid", snap_valid, 0);
    check("rst_cfg_mismatch", cfg_mismatch, 0);
  endtask

  // Host holds a request until the model says it was accepted.
  task automatic drive(input int unsigned pct);
    if (!cfg_valid || accepted) begin
      if ($urandom_range(99) < pct) begin
        cfg_valid = 1'b1;
        cfg_data  = $urandom;
      end else begin
        cfg_valid = 1'b0;
      end
    end
  endtask

  task automatic step(input int unsigned pct);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
    drive(pct);
  endtask

  // Slave: read strobe seen in a cycle is sampled at the next edge; data must be
  // present for the edge RD_LAT later and is scrambled right after it.
  initial begin
    logic [7:0] a;
    forever begin
      @(negedge clk);
      if (mm_read_en === 1'b1) begin
        a = mm_addr;
        @(posedge clk);
        repeat (L - 1) @(posedge clk);
        #1 mm_rdata = (a == 8'h01) ? stat_val : (a == 8'h02) ? err_val : readback_word(wr_word);
        @(posedge clk);
        #1 mm_rdata = $urandom;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    model_reset();
    nxt_stat = 32'h25;
    nxt_err  = 32'h04030201;
    stat_val = '0;
    err_val  = '0;
    repeat (3) @(negedge clk);
    #1 check_zero();
    @(negedge clk);
    rstn = 1'b1;
    model_reset();
    #1 check_outputs();
    drive(0);

    // First poll untouched, then a config request in the cycle the next expiry is pending.
    while (c < 39) step(0);
    cfg_valid = 1'b1;
    cfg_data  = 32'h001EC5A1;
    repeat (30) step(0);
`ifdef QOS_MM_CFG_READBACK_EN
    cfg_valid = 1'b1;
    cfg_data  = 32'h00000003;
    repeat (60) step(0);
`endif

    repeat (300) step(30);

    // Reset asserted mid error-wait.
    guard = 0;
    while (c != poll_t + 2 + L && guard < 200) begin
      step(10);
      guard++;
    end
    check("reached_wt_err", {31'b0, c == poll_t + 2 + L}, 32'd1);
    #2 rstn = 1'b0;
    cfg_valid = 1'b0;
    #1 check_zero();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    model_reset();
    #1 check_outputs();
    drive(0);
    repeat (30) step(0);
    repeat (150) step(25);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
